// File: rtl/mips_pkg.sv
// Shared MIPS definitions: memory opcodes, MEM-stage FSM states and access sizes.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Any opcode outside the byte/half set is handled as a full word.
  function automatic size_t op_size(input logic [5:0] op);
    size_t s;
    case (op)
      OP_LB, OP_LBU, OP_SB: s = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: s = SZ_HALF;
      default:              s = SZ_WORD;
    endcase
    return s;
  endfunction

  function automatic logic op_unsigned(input logic [5:0] op);
    return (op == OP_LBU) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: store byte enables / lane replication, alignment check,
// and load lane extraction with sign or zero extension (little-endian lanes).
module mem_lane_align
  import mips_pkg::*;
(
  input  size_t       size,
  input  logic        zext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        aligned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    aligned   = 1'b1;
    be        = 4'hF;
    wdata     = store_data;
    load_data = rdata;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = zext ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        aligned   = ~addr_lo[0];
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = zext ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        aligned = (addr_lo == 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: data-memory access over a req/ready bus with timeout, pipeline
// stall generation and the MEM/WB pipeline register.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] aluout,
  input  logic [31:0] rd2,
  input  logic [4:0]  rd,
  input  logic [5:0]  op,
  input  logic        memr,
  input  logic        memw,
  input  logic        regw,
  input  logic        mem2r,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  output logic        stall,
  output logic        addr_err,
  output logic        bus_err,
  output logic [31:0] wb_aluout,
  output logic [31:0] wb_memdata,
  output logic [4:0]  wb_rd,
  output logic        wb_regw,
  output logic        wb_mem2r
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t        state;
  logic [CW-1:0] cnt;

  size_t       size;
  logic        aligned;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load_data;

  logic mem_op, access, misaligned, idle, busy, timeout, complete, err;

  assign size = op_size(op);

  mem_lane_align u_align (
    .size       (size),
    .zext       (op_unsigned(op)),
    .addr_lo    (aluout[1:0]),
    .store_data (rd2),
    .rdata      (dm_rdata),
    .aligned    (aligned),
    .be         (be),
    .wdata      (wdata),
    .load_data  (load_data)
  );

  assign mem_op     = memr | memw;
  assign access     = mem_op & aligned;
  assign misaligned = mem_op & ~aligned;
  assign idle       = (state == ST_IDLE);
  assign busy       = (state == ST_BUSY);
  assign timeout    = busy & ~dm_ready & (cnt == CW'(TIMEOUT - 1));
  assign complete   = (idle & access & dm_ready) | (busy & dm_ready);
  assign err        = (idle & misaligned) | timeout;

  // Bus and status outputs are gated by rst_n so an aborted request disappears immediately.
  assign dm_req   = rst_n & ((idle & access) | busy);
  assign dm_we    = dm_req & memw;
  assign dm_addr  = dm_req ? {aluout[31:2], 2'b00} : 32'h0;
  assign dm_be    = dm_req ? be : 4'h0;
  assign dm_wdata = dm_we ? wdata : 32'h0;
  assign stall    = rst_n & ((idle & access & ~dm_ready) | (busy & ~dm_ready & ~timeout));
  assign addr_err = rst_n & idle & misaligned;
  assign bus_err  = rst_n & timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access && !dm_ready) begin
            state <= ST_BUSY;
            cnt   <= CW'(1);
          end
        end
        ST_BUSY: begin
          if (dm_ready || timeout) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // MEM/WB register: a stalled cycle injects a bubble and holds the data fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_aluout  <= '0;
      wb_memdata <= '0;
      wb_rd      <= '0;
      wb_regw    <= 1'b0;
      wb_mem2r   <= 1'b0;
    end else if (stall) begin
      wb_regw  <= 1'b0;
      wb_mem2r <= 1'b0;
    end else begin
      wb_aluout  <= aluout;
      wb_rd      <= rd;
      wb_regw    <= regw & ~err;
      wb_mem2r   <= mem2r & memr & ~err;
      wb_memdata <= (complete && memr) ? load_data : 32'h0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: driver issues EX/MEM instructions and a
// memory response; a monitor compares each MEM/WB capture against exp_q.
module tb_mem_access_unit;
  import mips_pkg::*;

  localparam int TO = 4;
  localparam int EW = 71;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] aluout = '0;
  logic [31:0] rd2 = '0;
  logic [4:0]  rd = '0;
  logic [5:0]  op = '0;
  logic        memr = 1'b0, memw = 1'b0, regw = 1'b0, mem2r = 1'b0;
  logic        dm_ready = 1'b0;
  logic [31:0] dm_rdata = '0;
  logic        dm_req, dm_we, stall, addr_err, bus_err;
  logic [31:0] dm_addr, dm_wdata, wb_aluout, wb_memdata;
  logic [3:0]  dm_be;
  logic [4:0]  wb_rd;
  logic        wb_regw, wb_mem2r;

  logic          in_valid = 1'b0;
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .aluout     (aluout),
    .rd2        (rd2),
    .rd         (rd),
    .op         (op),
    .memr       (memr),
    .memw       (memw),
    .regw       (regw),
    .mem2r      (mem2r),
    .dm_ready   (dm_ready),
    .dm_rdata   (dm_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_be      (dm_be),
    .dm_wdata   (dm_wdata),
    .stall      (stall),
    .addr_err   (addr_err),
    .bus_err    (bus_err),
    .wb_aluout  (wb_aluout),
    .wb_memdata (wb_memdata),
    .wb_rd      (wb_rd),
    .wb_regw    (wb_regw),
    .wb_mem2r   (wb_mem2r)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: an edge with stall low captures an instruction; with stall high it is a bubble.
  always @(posedge clk) begin : monitor
    logic          s, v;
    logic [EW-1:0] e;
    s = stall;
    v = in_valid;
    #1;
    if (rst_n && v) begin
      if (s) begin
        check("bubble_regw", {31'b0, wb_regw}, 32'h0);
        check("bubble_mem2r", {31'b0, wb_mem2r}, 32'h0);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected actual=capture required=empty_queue");
      end else begin
        e = exp_q.pop_front();
        check("wb_aluout", wb_aluout, e[70:39]);
        check("wb_memdata", wb_memdata, e[38:7]);
        check("wb_rd", {27'b0, wb_rd}, {27'b0, e[6:2]});
        check("wb_regw", {31'b0, wb_regw}, {31'b0, e[1]});
        check("wb_mem2r", {31'b0, wb_mem2r}, {31'b0, e[0]});
      end
    end
  end

  // Driver: presents one instruction, plays memory with 'waits' wait cycles, holds it under stall.
  task automatic run_op(
    input logic [5:0]  o,
    input logic        r, w, rw, m2r,
    input logic [31:0] a, d,
    input logic [4:0]  dst,
    input int          waits,
    input logic [31:0] rdat,
    input logic [3:0]  e_be,
    input logic [31:0] e_wd, e_mem,
    input logic        e_regw, e_m2r,
    input int          e_stall,
    input logic        e_aerr, e_berr
  );
    int   n, stall_cnt, berr_at;
    logic st, e_req;
    @(negedge clk);
    op = o; memr = r; memw = w; regw = rw; mem2r = m2r;
    aluout = a; rd2 = d; rd = dst; dm_rdata = rdat;
    dm_ready = (waits == 0);
    in_valid = 1'b1;
    exp_q.push_back({a, e_mem, dst, e_regw, e_m2r});
    e_req = (r | w) & ~e_aerr;
    stall_cnt = 0;
    berr_at = -1;
    #1;
    check("dm_req", {31'b0, dm_req}, {31'b0, e_req});
    check("addr_err", {31'b0, addr_err}, {31'b0, e_aerr});
    if (e_req) begin
      check("dm_addr", dm_addr, {a[31:2], 2'b00});
      check("dm_be", {28'b0, dm_be}, {28'b0, e_be});
      check("dm_we", {31'b0, dm_we}, {31'b0, w});
      if (w) check("dm_wdata", dm_wdata, e_wd);
    end
    for (n = 0; n < 40; n++) begin
      if (n > 0) begin
        @(negedge clk);
        dm_ready = (n == waits);
        #1;
        check("dm_req_hold", {31'b0, dm_req}, 32'h1);
      end
      if (bus_err) berr_at = n;
      st = stall;
      if (st) stall_cnt++;
      @(posedge clk);
      if (!st) break;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL op_complete actual=no_completion required=stall_release");
    end
    check("stall_cycles", stall_cnt, e_stall);
    check("bus_err_cycle", berr_at, e_berr ? TO - 1 : -1);
    @(negedge clk);
    op = '0; memr = 1'b0; memw = 1'b0; regw = 1'b0; mem2r = 1'b0;
    dm_ready = 1'b0; in_valid = 1'b0;
    #1;
    if (e_berr) check("dm_req_drop", {31'b0, dm_req}, 32'h0);
  endtask

  initial begin : stimulus
    #2;
    check("rst_dm_req", {31'b0, dm_req}, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_wb_aluout", wb_aluout, 32'h0);
    check("rst_wb_memdata", wb_memdata, 32'h0);
    check("rst_wb_regw", {31'b0, wb_regw}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //     op      r  w  rw m2r addr          rd2           rd  wt  rdata         be       wdata         memdata       rw m2r st ae be
    run_op(OP_LW,  1, 0, 1, 1, 32'h100, 32'h0,        5'd8, 0,  32'hDEADBEEF, 4'hF,    32'h0,        32'hDEADBEEF, 1, 1, 0, 0, 0);
    run_op(OP_LB,  1, 0, 1, 1, 32'h103, 32'h0,        5'd4, 3,  32'h80123456, 4'b1000, 32'h0,        32'hFFFFFF80, 1, 1, 3, 0, 0);
    run_op(OP_LBU, 1, 0, 1, 1, 32'h103, 32'h0,        5'd5, 3,  32'h80123456, 4'b1000, 32'h0,        32'h00000080, 1, 1, 3, 0, 0);
    run_op(OP_LH,  1, 0, 1, 0, 32'h100, 32'h0,        5'd6, 1,  32'h1234F00D, 4'b0011, 32'h0,        32'hFFFFF00D, 1, 0, 1, 0, 0);
    run_op(OP_LHU, 1, 0, 1, 1, 32'h102, 32'h0,        5'd7, 0,  32'h80015555, 4'b1100, 32'h0,        32'h00008001, 1, 1, 0, 0, 0);
    run_op(OP_SH,  0, 1, 0, 0, 32'h102, 32'h1234ABCD, 5'd0, 0,  32'h0,        4'b1100, 32'hABCDABCD, 32'h0,        0, 0, 0, 0, 0);
    run_op(OP_SB,  0, 1, 0, 0, 32'h101, 32'h000000A5, 5'd0, 2,  32'h0,        4'b0010, 32'hA5A5A5A5, 32'h0,        0, 0, 2, 0, 0);
    run_op(OP_SW,  0, 1, 0, 0, 32'h104, 32'hCAFEF00D, 5'd0, 0,  32'h0,        4'hF,    32'hCAFEF00D, 32'h0,        0, 0, 0, 0, 0);
    run_op(OP_LW,  1, 0, 1, 1, 32'h101, 32'h0,        5'd9, 0,  32'h11111111, 4'h0,    32'h0,        32'h0,        0, 0, 0, 1, 0);
    run_op(OP_SH,  0, 1, 0, 0, 32'h103, 32'h5555,     5'd0, 0,  32'h0,        4'h0,    32'h0,        32'h0,        0, 0, 0, 1, 0);
    run_op(OP_LW,  1, 0, 1, 1, 32'h200, 32'h0,        5'd7, 99, 32'h22222222, 4'hF,    32'h0,        32'h0,        0, 0, 3, 0, 1);
    run_op(6'h00,  0, 0, 1, 0, 32'h55,  32'h0,        5'd3, 0,  32'h33333333, 4'h0,    32'h0,        32'h0,        1, 0, 0, 0, 0);
    run_op(6'h3F,  1, 0, 1, 1, 32'h108, 32'h0,        5'd2, 0,  32'h12345678, 4'hF,    32'h0,        32'h12345678, 1, 1, 0, 0, 0);

    // Reset in the middle of a waited access aborts it and clears MEM/WB.
    @(negedge clk);
    op = OP_LW; memr = 1'b1; regw = 1'b1; mem2r = 1'b1;
    aluout = 32'h300; rd = 5'd9; dm_ready = 1'b0; dm_rdata = 32'h44444444;
    @(negedge clk);
    #1;
    check("busy_dm_req", {31'b0, dm_req}, 32'h1);
    check("busy_stall", {31'b0, stall}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_dm_req", {31'b0, dm_req}, 32'h0);
    check("abort_stall", {31'b0, stall}, 32'h0);
    check("abort_wb_aluout", wb_aluout, 32'h0);
    check("abort_wb_memdata", wb_memdata, 32'h0);
    check("abort_wb_rd", {27'b0, wb_rd}, 32'h0);
    check("abort_wb_regw", {31'b0, wb_regw}, 32'h0);
    @(negedge clk);
    memr = 1'b0; regw = 1'b0; mem2r = 1'b0; op = '0;
    rst_n = 1'b1;

    run_op(OP_LW,  1, 0, 1, 1, 32'h400, 32'h0,        5'd10, 2, 32'h0BADF00D, 4'hF,    32'h0,        32'h0BADF00D, 1, 1, 2, 0, 0);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL exp_q_drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage consumer of the EX/MEM pipeline register: takes the registered ALU result, store data, destination register and memory/write-back controls, and performs the data-memory access over a ready/request bus with byte-lane alignment. Drives a pipeline stall while the memory is busy. Its outputs are the MEM/WB pipeline register, so it is the downstream end of the EX/MEM interface and the upstream end of write-back.

## Interface
- TIMEOUT, 16: maximum BUSY cycles before a bus error is raised (≥2).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- aluout  in  32  effective address / ALU result, from EX/MEM.
- rd2  in  32  store data, from EX/MEM.
- rd  in  5  destination register, from EX/MEM.
- op  in  6  MIPS opcode, from EX/MEM.
- memr, memw, regw, mem2r  in  1 each  controls, from EX/MEM.
- dm_ready  in  1  memory completes the current request this cycle.
- dm_rdata  in  32  word read data, valid with dm_ready.
- dm_req  out  1  access request.
- dm_we  out  1  write request.
- dm_addr  out  32  word address, {aluout[31:2],2'b00}.
- dm_be  out  4  byte enables, lane i = bits 8i+7:8i, little-endian.
- dm_wdata  out  32  store data replicated into lanes.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- addr_err  out  1  one-cycle pulse, misaligned access.
- bus_err  out  1  one-cycle pulse, timeout.
- wb_aluout, wb_memdata  out  32 each  MEM/WB register.
- wb_rd  out  5; wb_regw, wb_mem2r  out  1 each  MEM/WB register.

## Operation
- Supported ops: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B. If memr|memw is set with any other op, the unit treats it as lw/sw.
- access = (memr|memw) & aligned. Halfword needs aluout[0]=0; word needs aluout[1:0]=0.
- Misaligned: no dm_req, addr_err=1 for that cycle, no stall. The MEM/WB capture has wb_regw=0.
- Byte enables: byte 4'b0001<<a[1:0]; half a[1]?4'b1100:4'b0011; word 4'b1111. dm_wdata: byte {4{rd2[7:0]}}, half {2{rd2[15:0]}}, word rd2.
- Load extract: select lane by a[1:0]. lb/lh sign-extend; lbu/lhu zero-extend.
- FSM IDLE/BUSY; state and counter reset to IDLE/0.
  - IDLE:
    - dm_req = access, driven combinationally from the inputs; EX/MEM holds them stable under stall.
    - If access & !dm_ready, go to BUSY with cnt=1.
    - If access & dm_ready, complete with zero wait.
  - BUSY:
    - dm_req=1 with the same addr/be/wdata.
    - On dm_ready, complete and go to IDLE.
    - If cnt==TIMEOUT-1 & !dm_ready: bus_err=1, drop dm_req next cycle, go to IDLE. The capture has wb_regw=0, wb_mem2r=0.
    - Otherwise cnt++.
- stall = (IDLE & access & !dm_ready) | (BUSY & !dm_ready & !timeout).
- MEM/WB capture, every edge:
  - When stall=0: wb_aluout<=aluout, wb_rd<=rd, wb_regw<=regw&!err, wb_mem2r<=mem2r&memr&!err, and wb_memdata<=extracted data if the op is a completing load, else 0.
  - When stall=1: wb_regw<=0 and wb_mem2r<=0 (bubble). The other wb_* fields hold.
- dm_ready outside a request is ignored.

## Timing
- Reset: every output is 0, state IDLE, cnt 0. Reset mid-BUSY aborts the request immediately; the result is never written back.
- Zero-wait access: the request and completion fall in the same cycle as EX/MEM presents it; wb_* is valid after the next edge; no stall.
- N wait cycles: stall is high for N cycles; wb_* is valid on the edge of the dm_ready cycle.
- Timeout: bus_err is asserted in cycle TIMEOUT of the access, counting the IDLE cycle as 1; stall is low that cycle.
- Non-memory instructions pass through in one cycle: wb_* = EX/MEM values, registered.

## Structure
- Shared package mips_pkg: opcode localparams (OP_LB … OP_SW), the state enum, and the size encoding (BYTE/HALF/WORD).
- One sub-module, mem_lane_align: combinational; generates be/wdata for stores and performs load extraction/extension; reused by later cache work.
- The FSM, the counter and the MEM/WB registers live in mem_access_unit.

## Test plan
- Zero-wait lw, aluout=0x100, dm_rdata=0xDEADBEEF, regw=1, rd=8 -> dm_be=4'hF, stall never high, next cycle wb_memdata=0xDEADBEEF, wb_regw=1, wb_rd=8.
- lb at 0x103, 3 wait cycles, dm_rdata=0x80xxxxxx -> stall high 3 cycles, dm_be=4'b1000, wb_memdata=0xFFFFFF80; lbu same -> 0x00000080.
- sh at 0x102 with rd2=0x1234ABCD, zero wait -> dm_we=1, dm_be=4'b1100, dm_wdata=0xABCDABCD.
- lw at 0x101 -> dm_req=0, addr_err pulse, stall=0, wb_regw=0.
- TIMEOUT=4, dm_ready stuck 0 -> stall high 3 cycles, bus_err in cycle 4, then dm_req=0 and wb_regw=0.
- rst_n low during BUSY -> dm_req, stall and wb_* go to 0 at once; after release, the next access runs normally.
